// File: rtl/asteroid_pkg.sv
// Shared types and playfield constants for the meteor scheduler.
// Imported by meteor_slot and meteor_scheduler.
package asteroid_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FALLING = 2'd1,
        S_EXPLODE = 2'd2
    } slot_state_t;

    localparam logic [9:0] TOP_START = 10'd35;
    localparam logic [9:0] METEOR_H  = 10'd30;
    localparam logic [9:0] DEF_TOP   = 10'd376;
    localparam logic [9:0] DEF_BOT   = 10'd416;
    localparam logic [9:0] FLOOR     = 10'd515;
    localparam logic [9:0] MID_BASE  = 10'd160;
    localparam logic [9:0] LFSR_SEED = 10'h2A5;

endpackage

// File: rtl/meteor_slot.sv
// One meteor slot: IDLE / FALLING / EXPLODE, updated on frame_tick only.
// Ports: clk, reset, frame_tick, defense_on, freeze, spawn, spawn_mid in;
//        active, exploding, top, mid, kill/miss event strobes out.
module meteor_slot
    import asteroid_pkg::*;
#(
    parameter int EXPL_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       defense_on,
    input  logic       freeze,
    input  logic       spawn,
    input  logic [9:0] spawn_mid,
    output logic       active,
    output logic       exploding,
    output logic [9:0] top,
    output logic [9:0] mid,
    output logic       kill,
    output logic       miss
);
    localparam int CW = $clog2(EXPL_FRAMES + 1);

    slot_state_t   state, state_n;
    logic [9:0]    top_n, mid_n, bot;
    logic [CW-1:0] ecnt, ecnt_n;
    logic          in_zone, move;

    // Zone test uses the pre-increment position of this tick.
    assign bot     = top + METEOR_H;
    assign in_zone = ((top >= DEF_TOP) && (top <= DEF_BOT)) ||
                     ((bot >= DEF_TOP) && (bot <= DEF_BOT));
    assign move    = frame_tick && !freeze && (state == S_FALLING);
    assign kill    = move && defense_on && in_zone;
    assign miss    = move && !kill && (top >= FLOOR);

    assign active    = (state == S_FALLING);
    assign exploding = (state == S_EXPLODE);

    always_comb begin
        state_n = state;
        top_n   = top;
        mid_n   = mid;
        ecnt_n  = ecnt;
        if (frame_tick) begin
            unique case (state)
                S_IDLE: begin
                    if (spawn) begin
                        state_n = S_FALLING;
                        top_n   = TOP_START;
                        mid_n   = spawn_mid;
                    end
                end
                S_FALLING: begin
                    if (kill) begin
                        state_n = S_EXPLODE;
                        ecnt_n  = '0;
                    end else if (miss) begin
                        state_n = S_IDLE;
                    end else if (move) begin
                        top_n = top + 10'd1;
                    end
                end
                S_EXPLODE: begin
                    if (ecnt == CW'(EXPL_FRAMES - 1)) begin
                        state_n = S_IDLE;
                    end else begin
                        ecnt_n = ecnt + CW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            top   <= TOP_START;
            mid   <= '0;
            ecnt  <= '0;
        end else begin
            state <= state_n;
            top   <= top_n;
            mid   <= mid_n;
            ecnt  <= ecnt_n;
        end
    end

endmodule

// File: rtl/meteor_scheduler.sv
// Meteor scheduler: spawn timing, LFSR, slot arbitration, score/miss/game-over.
// Ports: clk, reset, frame_tick, spawn_en, defense_on, hit in; per-slot
//        status buses, expl_start, pixel_on/pixel_slot, score, misses, game_over out.
module meteor_scheduler
    import asteroid_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_FRAMES = 60,
    parameter int EXPL_FRAMES  = 16,
    parameter int MAX_MISSES   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    spawn_en,
    input  logic                    defense_on,
    input  logic [NUM_SLOTS-1:0]    hit,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [10*NUM_SLOTS-1:0] slot_mid,
    output logic [10*NUM_SLOTS-1:0] slot_top,
    output logic [NUM_SLOTS-1:0]    expl_start,
    output logic [NUM_SLOTS-1:0]    exploding,
    output logic                    pixel_on,
    output logic [1:0]              pixel_slot,
    output logic [7:0]              score,
    output logic [3:0]              misses,
    output logic                    game_over
);
    localparam int CW = $clog2(SPAWN_FRAMES + 1);

    logic [9:0]           lfsr, spawn_mid;
    logic [CW-1:0]        spawn_cnt;
    logic                 spawn_try;
    logic [NUM_SLOTS-1:0] idle_v, grant, spawn_v, kill_v, miss_v, hv;
    logic [7:0]           kill_cnt;
    logic [3:0]           miss_cnt, misses_n;
    logic [8:0]           score_sum;

    assign spawn_try = frame_tick && (spawn_cnt == CW'(SPAWN_FRAMES - 1));
    assign spawn_mid = MID_BASE + {1'b0, lfsr[8:0]};

    // Grant is taken from pre-tick state, so a slot freed this tick
    // is never reused by the same spawn attempt.
    assign idle_v  = ~(slot_active | exploding);
    assign grant   = idle_v & ((~idle_v) + NUM_SLOTS'(1));
    assign spawn_v = (spawn_try && spawn_en && !game_over) ? grant : '0;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        meteor_slot #(
            .EXPL_FRAMES(EXPL_FRAMES)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .frame_tick(frame_tick),
            .defense_on(defense_on),
            .freeze    (game_over),
            .spawn     (spawn_v[i]),
            .spawn_mid (spawn_mid),
            .active    (slot_active[i]),
            .exploding (exploding[i]),
            .top       (slot_top[i*10 +: 10]),
            .mid       (slot_mid[i*10 +: 10]),
            .kill      (kill_v[i]),
            .miss      (miss_v[i])
        );
    end

    always_comb begin
        kill_cnt = '0;
        miss_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            kill_cnt = kill_cnt + 8'(kill_v[i]);
            miss_cnt = miss_cnt + 4'(miss_v[i]);
        end
        score_sum = {1'b0, score} + {1'b0, kill_cnt};
        misses_n  = misses + miss_cnt;
    end

    always_comb begin
        hv         = hit & slot_active;
        pixel_on   = |hv;
        pixel_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hv[i]) pixel_slot = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            spawn_cnt  <= '0;
            score      <= '0;
            misses     <= '0;
            game_over  <= 1'b0;
            expl_start <= '0;
        end else begin
            lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            expl_start <= kill_v;
            if (frame_tick) begin
                spawn_cnt <= spawn_try ? '0 : spawn_cnt + CW'(1);
                score     <= score_sum[8] ? 8'hFF : score_sum[7:0];
                misses    <= misses_n;
                if (misses_n >= 4'(MAX_MISSES)) game_over <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_meteor_scheduler.sv
// Self-checking bench for meteor_scheduler.
// Reference model feeds a scoreboard queue; directed checks cover key scenarios.
module tb_meteor_scheduler;

    logic        clk = 1'b0;
    logic        reset, frame_tick, spawn_en, defense_on;
    logic [3:0]  hit;
    logic [3:0]  slot_active, expl_start, exploding;
    logic [39:0] slot_mid, slot_top;
    logic        pixel_on, game_over;
    logic [1:0]  pixel_slot;
    logic [7:0]  score;
    logic [3:0]  misses;

    meteor_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .spawn_en   (spawn_en),
        .defense_on (defense_on),
        .hit        (hit),
        .slot_active(slot_active),
        .slot_mid   (slot_mid),
        .slot_top   (slot_top),
        .expl_start (expl_start),
        .exploding  (exploding),
        .pixel_on   (pixel_on),
        .pixel_slot (pixel_slot),
        .score      (score),
        .misses     (misses),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  act;
        logic [3:0]  expl;
        logic [3:0]  es;
        logic [39:0] top;
        logic [39:0] mid;
        logic [7:0]  score;
        logic [3:0]  miss;
        logic        go;
    } snap_t;

    snap_t sb[$];

    // Reference model state
    int         m_st[4];
    int         m_top[4];
    int         m_mid[4];
    int         m_ec[4];
    int         m_cnt, m_score, m_miss;
    bit         m_go;
    logic [9:0] m_lfsr;
    logic [3:0] m_es;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_top[i] = 35; m_mid[i] = 0; m_ec[i] = 0;
        end
        m_cnt = 0; m_score = 0; m_miss = 0; m_go = 0;
        m_lfsr = 10'h2A5; m_es = '0;
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit en,
                              input bit def);
        logic [9:0] lf;
        bit try_sp;
        int free, k, ms, t;
        if (rst) begin
            model_reset();
            return;
        end
        lf = m_lfsr;
        m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        m_es = '0;
        if (!tk) return;
        try_sp = (m_cnt == 59);
        m_cnt = try_sp ? 0 : m_cnt + 1;
        free = -1;
        for (int i = 0; i < 4; i++)
            if (m_st[i] == 0 && free < 0) free = i;
        k = 0; ms = 0;
        for (int i = 0; i < 4; i++) begin
            t = m_top[i];
            if (m_st[i] == 1 && !m_go) begin
                if (def && ((t >= 376 && t <= 416) ||
                            (t + 30 >= 376 && t + 30 <= 416))) begin
                    m_st[i] = 2; m_ec[i] = 0; k++; m_es[i] = 1'b1;
                end else if (t >= 515) begin
                    m_st[i] = 0; ms++;
                end else begin
                    m_top[i] = t + 1;
                end
            end else if (m_st[i] == 2) begin
                if (m_ec[i] == 15) m_st[i] = 0;
                else m_ec[i]++;
            end
        end
        if (try_sp && en && !m_go && free >= 0) begin
            m_st[free] = 1; m_top[free] = 35;
            m_mid[free] = 160 + int'(lf[8:0]);
        end
        m_score = (m_score + k > 255) ? 255 : m_score + k;
        m_miss += ms;
        if (m_miss >= 8) m_go = 1;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < 4; i++) begin
            s.act[i]          = (m_st[i] == 1);
            s.expl[i]         = (m_st[i] == 2);
            s.top[i*10 +: 10] = 10'(m_top[i]);
            s.mid[i*10 +: 10] = 10'(m_mid[i]);
        end
        s.es    = m_es;
        s.score = 8'(m_score);
        s.miss  = 4'(m_miss);
        s.go    = m_go;
        return s;
    endfunction

    // One clock cycle: drive, check combinational pixel outputs, predict,
    // clock, then pop the prediction and compare registered outputs.
    task automatic cyc(input bit rst, input bit tk, input bit en,
                       input bit def, input logic [3:0] h);
        logic [3:0] av, hv;
        logic [1:0] ps;
        snap_t e;
        reset = rst; frame_tick = tk; spawn_en = en;
        defense_on = def; hit = h;
        #2;
        for (int i = 0; i < 4; i++) av[i] = (m_st[i] == 1);
        hv = h & av;
        ps = 2'd0;
        for (int i = 3; i >= 0; i--) if (hv[i]) ps = 2'(i);
        check("pixel_on", 64'(pixel_on), 64'(|hv));
        check("pixel_slot", 64'(pixel_slot), 64'(ps));
        model_step(rst, tk, en, def);
        sb.push_back(model_snap());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("slot_active", 64'(slot_active), 64'(e.act));
        check("exploding", 64'(exploding), 64'(e.expl));
        check("expl_start", 64'(expl_start), 64'(e.es));
        check("slot_top", 64'(slot_top), 64'(e.top));
        check("slot_mid", 64'(slot_mid), 64'(e.mid));
        check("score", 64'(score), 64'(e.score));
        check("misses", 64'(misses), 64'(e.miss));
        check("game_over", 64'(game_over), 64'(e.go));
    endtask

    initial begin
        bit es_seen, miss_hit, found;
        int mid0;

        reset = 1'b1; frame_tick = 1'b0; spawn_en = 1'b0;
        defense_on = 1'b0; hit = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        cyc(1, 0, 0, 0, 4'h0);
        check("rst_top", 64'(slot_top), 64'({4{10'd35}}));
        check("rst_mid", 64'(slot_mid), 64'd0);
        check("rst_active", 64'(slot_active), 64'd0);
        check("rst_score", 64'(score), 64'd0);

        // First spawn after 60 ticks
        for (int i = 0; i < 60; i++) cyc(0, 1, 1, 0, 4'($urandom_range(0, 15)));
        check("spawn_act", 64'(slot_active), 64'h1);
        check("spawn_top0", 64'(slot_top[9:0]), 64'd35);
        mid0 = int'(slot_mid[9:0]);
        check("spawn_mid_rng", 64'(mid0 >= 160 && mid0 <= 671), 64'd1);
        check("spawn_s1_idle", 64'({slot_active[1], exploding[1]}), 64'd0);

        // Defense off: misses accumulate to game over
        es_seen = 0; miss_hit = 0;
        for (int i = 0; i < 3000 && !game_over; i++) begin
            cyc(0, ($urandom_range(0, 3) != 0), 1, 0, 4'($urandom_range(0, 15)));
            if (expl_start != 0) es_seen = 1;
            if (!miss_hit && misses == 4'd1) begin
                miss_hit = 1;
                check("miss1_slot0", 64'({slot_active[0], exploding[0]}), 64'd0);
                check("miss1_top0", 64'(slot_top[9:0]), 64'd515);
            end
        end
        check("miss_seen", 64'(miss_hit), 64'd1);
        check("no_expl_def_off", 64'(es_seen), 64'd0);
        check("go_set", 64'(game_over), 64'd1);
        check("go_misses", 64'(misses), 64'd8);
        for (int i = 0; i < 150; i++) cyc(0, 1, 1, 1, 4'($urandom_range(0, 15)));
        check("go_sticky", 64'(game_over), 64'd1);

        // Reset with frame_tick in the same cycle, then defense kill
        cyc(1, 1, 1, 1, 4'h0);
        check("rst_go_clr", 64'(game_over), 64'd0);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cyc(0, 1, 1, 1, 4'($urandom_range(0, 15)));
            if (expl_start[0]) found = 1;
        end
        check("kill_seen", 64'(found), 64'd1);
        check("kill_top", 64'(slot_top[9:0]), 64'd346);
        check("kill_score", 64'(score), 64'd1);
        for (int i = 0; i < 15; i++) cyc(0, 1, 1, 1, 4'h0);
        check("expl_15", 64'(exploding[0]), 64'd1);
        cyc(0, 1, 1, 1, 4'h0);
        check("expl_16", 64'({slot_active[0], exploding[0]}), 64'd0);

        // Reset on the tick that would kill slot1
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_st[1] == 1 && m_top[1] == 346) found = 1;
            else cyc(0, 1, 1, 1, 4'h0);
        end
        check("pre_kill_s1", 64'(found), 64'd1);
        cyc(1, 1, 1, 1, 4'h0);
        check("rst_es_supp", 64'(expl_start), 64'd0);
        check("rst_score0", 64'(score), 64'd0);

        // Fill all slots, then directed pixel arbitration
        for (int i = 0; i < 250; i++) cyc(0, 1, 1, 0, 4'($urandom_range(0, 15)));
        check("all_active", 64'(slot_active), 64'hF);
        hit = 4'b1110;
        #1;
        check("pix_on_1110", 64'(pixel_on), 64'd1);
        check("pix_slot_1110", 64'(pixel_slot), 64'd1);
        hit = 4'b0000;
        #1;
        check("pix_on_0", 64'(pixel_on), 64'd0);
        check("pix_slot_0", 64'(pixel_slot), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
